// File: rtl/alu_pkg.sv
// Shared definitions for the RV32I execute-stage ALU: control width and the
// funct3-style operation encoding.
package alu_pkg;

  localparam int unsigned ALU_CTRL_WIDTH = 3;

  typedef enum logic [ALU_CTRL_WIDTH-1:0] {
    ALU_ADD  = 3'd0,
    ALU_SLL  = 3'd1,
    ALU_SLT  = 3'd2,
    ALU_SLTU = 3'd3,
    ALU_XOR  = 3'd4,
    ALU_SRL  = 3'd5,
    ALU_OR   = 3'd6,
    ALU_AND  = 3'd7
  } alu_op_e;

endpackage

// File: rtl/alu_if.sv
// Operand/control/result bundle for the ALU; master drives operands, slave
// returns the registered result.
interface alu_if
  import alu_pkg::*;
#(
  parameter int unsigned W = 32
);

  logic [W-1:0]              din_0;
  logic [W-1:0]              din_1;
  logic [ALU_CTRL_WIDTH-1:0] ctrl;
  logic [W-1:0]              result;

  modport master (output din_0, output din_1, output ctrl, input result);
  modport slave  (input din_0, input din_1, input ctrl, output result);

endinterface

// File: rtl/alu_shifter.sv
// Logarithmic barrel shifter, logical left/right. A left shift is done as a
// right shift on bit-reversed data so only one shifter chain is built.
module alu_shifter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0]         data_i,
  input  logic [$clog2(WIDTH)-1:0] shamt_i,
  input  logic                     right_i,
  output logic [WIDTH-1:0]         data_o
);

  localparam int unsigned SHW = $clog2(WIDTH);

  function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      r[i] = v[WIDTH-1-i];
    end
    return r;
  endfunction

  logic [WIDTH-1:0] stage;

  always_comb begin
    stage = right_i ? data_i : bit_rev(data_i);
    for (int unsigned i = 0; i < SHW; i++) begin
      if (shamt_i[i]) begin
        stage = stage >> (1 << i);
      end
    end
    data_o = right_i ? stage : bit_rev(stage);
  end

endmodule

// File: rtl/alu.sv
// Registered RV32I integer ALU (ADD/SLT/SLTU/XOR/OR/AND), one cycle latency.
// Define ALU_SHIFT_EN to add SLL/SRL; otherwise those codes return zero.
module alu
  import alu_pkg::*;
#(
  parameter int unsigned REG_DATA_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      nreset,
  input  logic [REG_DATA_WIDTH-1:0] din_0,
  input  logic [REG_DATA_WIDTH-1:0] din_1,
  input  logic [ALU_CTRL_WIDTH-1:0] ctrl,
  output logic [REG_DATA_WIDTH-1:0] result
);

  logic [REG_DATA_WIDTH-1:0] result_d;
  logic [REG_DATA_WIDTH-1:0] result_q;

`ifdef ALU_SHIFT_EN
  logic [REG_DATA_WIDTH-1:0] shift_res;

  // ctrl[2] separates SRL (101) from SLL (001)
  alu_shifter #(
    .WIDTH (REG_DATA_WIDTH)
  ) u_shifter (
    .data_i  (din_0),
    .shamt_i (din_1[$clog2(REG_DATA_WIDTH)-1:0]),
    .right_i (ctrl[2]),
    .data_o  (shift_res)
  );
`endif

  always_comb begin
    result_d = '0;
    case (alu_op_e'(ctrl))
      ALU_ADD:  result_d = din_0 + din_1;
      ALU_SLT:  result_d[0] = $signed(din_0) < $signed(din_1);
      ALU_SLTU: result_d[0] = din_0 < din_1;
      ALU_XOR:  result_d = din_0 ^ din_1;
      ALU_OR:   result_d = din_0 | din_1;
      ALU_AND:  result_d = din_0 & din_1;
`ifdef ALU_SHIFT_EN
      ALU_SLL, ALU_SRL: result_d = shift_res;
`else
      ALU_SLL, ALU_SRL: result_d = '0;
`endif
      default:  result_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      result_q <= '0;
    end else begin
      result_q <= result_d;
    end
  end

  assign result = result_q;

endmodule

// File: tb/tb_alu.sv
// Randomised scoreboard bench for alu: stimulus pushes model results into a
// queue, a monitor pops one per clock edge and compares against the DUT.
module tb_alu;

  localparam int unsigned W = 32;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
  } sb_item_t;

  logic clk;
  logic nreset;
  int   vectors;
  int   miscompares;
  sb_item_t sb[$];

  alu_if #(.W(W)) bus ();

  alu #(
    .REG_DATA_WIDTH (W)
  ) dut (
    .clk    (clk),
    .nreset (nreset),
    .din_0  (bus.din_0),
    .din_1  (bus.din_1),
    .ctrl   (bus.ctrl),
    .result (bus.result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] ref_model(input logic [2:0] op,
                                             input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    longint unsigned sum;
    case (op)
      3'd0: begin
        sum = a;
        sum = sum + b;
        return W'(sum % (64'd1 << W));
      end
      3'd2: return (int'(a) < int'(b)) ? 1 : 0;
      3'd3: return (a < b) ? 1 : 0;
      3'd4: return a ^ b;
      3'd6: return a | b;
      3'd7: return a & b;
`ifdef ALU_SHIFT_EN
      3'd1: return a << (b % W);
      3'd5: return a >> (b % W);
`endif
      default: return 0;
    endcase
  endfunction

  task automatic check(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b);
    sb_item_t it;
    @(negedge clk);
    bus.ctrl  = op;
    bus.din_0 = a;
    bus.din_1 = b;
    it.op  = op;
    it.a   = a;
    it.b   = b;
    it.exp = ref_model(op, a, b);
    sb.push_back(it);
  endtask

  // Monitor: each rising edge out of reset consumes exactly one issued op
  initial begin
    sb_item_t it;
    forever begin
      @(posedge clk);
      if (nreset && sb.size() > 0) begin
        it = sb.pop_front();
        #1;
        check($sformatf("op%0d a=%08h b=%08h", it.op, it.a, it.b),
              bus.result, it.exp);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "timeout");
  end

  task automatic drain();
    int unsigned n;
    n = 0;
    while (sb.size() != 0 && n < 10) begin
      @(posedge clk);
      n++;
    end
    #2;
    if (sb.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: %0d items left, expected 0", sb.size());
      sb.delete();
    end
  endtask

  function automatic logic [W-1:0] rnd_operand();
    case ($urandom_range(0, 7))
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h0000_0000;
      3: return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [W-1:0] a, b;
    vectors     = 0;
    miscompares = 0;

    // Asynchronous reset with arbitrary inputs, before any clock edge
    nreset    = 1'b1;
    bus.din_0 = 32'hDEAD_BEEF;
    bus.din_1 = 32'h1234_5678;
    bus.ctrl  = 3'd0;
    #1 nreset = 1'b0;
    #1 check("reset_async", bus.result, '0);
    repeat (2) @(posedge clk);
    #1 check("reset_hold", bus.result, '0);

    // Directed corner cases, first one released from reset on the same negedge
    @(negedge clk);
    nreset = 1'b1;
    bus.ctrl = 3'd0; bus.din_0 = 32'hFFFF_FFFF; bus.din_1 = 32'hFFFF_FFFF;
    sb.push_back('{op: 3'd0, a: 32'hFFFF_FFFF, b: 32'hFFFF_FFFF, exp: 32'hFFFF_FFFE});
    issue(3'd0, 32'hFFFF_FFFF, 32'h0000_0001);
    issue(3'd2, 32'h8000_0000, 32'h0000_0001);
    issue(3'd3, 32'h8000_0000, 32'h0000_0001);
    issue(3'd2, 32'd5, 32'd5);
    issue(3'd3, 32'd5, 32'd5);
    issue(3'd4, 32'hF0F0_F0F0, 32'hFF00_FF00);
    issue(3'd6, 32'hF0F0_F0F0, 32'hFF00_FF00);
    issue(3'd7, 32'hF0F0_F0F0, 32'hFF00_FF00);
    issue(3'd1, 32'h8000_0001, 32'h0000_0021);
    issue(3'd5, 32'h8000_0001, 32'h0000_0021);
    drain();

    // Hard-coded spot check independent of the model
    check("add_wrap_const", ref_model(3'd0, 32'hFFFF_FFFF, 32'h1), 32'h0);

    // Random: op changes every cycle, 100 pairs per op
    for (int i = 0; i < 100; i++) begin
      for (int op = 0; op < 8; op++) begin
        a = rnd_operand();
        b = ($urandom_range(0, 9) == 0) ? a : rnd_operand();
        issue(3'(op), a, b);
      end
    end
    drain();

    // Mid-stream reset: async clear, then first edge after release captures inputs
    @(posedge clk);
    #3 nreset = 1'b0;
    #1 check("reset_mid_async", bus.result, '0);
    repeat (2) @(posedge clk);
    #1 check("reset_mid_hold", bus.result, '0);
    @(negedge clk);
    nreset = 1'b1;
    bus.ctrl = 3'd6; bus.din_0 = 32'h0000_00F0; bus.din_1 = 32'h0000_000F;
    sb.push_back('{op: 3'd6, a: 32'h0000_00F0, b: 32'h0000_000F, exp: 32'h0000_00FF});
    issue(3'd0, 32'h7FFF_FFFF, 32'h0000_0001);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
